// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package deser_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_t;

  localparam int DESER_DATA_W = 16;

endpackage

// File: rtl/deser_out_slot.sv
// One-entry valid/ready output register; drops an incoming word when full and not draining.
module deser_out_slot #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = 5
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [MOD_W-1:0]  mod_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [MOD_W-1:0]  mod_o,
  output logic              valid_o,
  output logic              drop_o
);

  logic [DATA_W-1:0] r_data;
  logic [MOD_W-1:0]  r_mod;
  logic              r_valid;
  logic              r_drop;
  logic              w_xfer;
  logic              w_accept;

  // Handshake: a word moves on any edge where valid_o and ready_i are both high;
  // data_o/mod_o stay frozen while valid_o is high and ready_i is low.
  assign w_xfer   = r_valid & ready_i;
  assign w_accept = load_i & (~r_valid | w_xfer);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_data  <= '0;
      r_mod   <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= load_i & r_valid & ~ready_i;
      if (w_accept) begin
        r_data  <= word_i;
        r_mod   <= mod_i;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o  = r_data;
  assign mod_o   = r_mod;
  assign valid_o = r_valid;
  assign drop_o  = r_drop;

endmodule

// File: rtl/deserializer.sv
// Samples a serial stream MSB-first into left-aligned words and hands them to a one-entry output slot.
module deserializer
  import deser_pkg::*;
#(
  parameter  int DATA_W = DESER_DATA_W,
  localparam int MOD_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  input  logic              deser_ready_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              overflow_o,
  output deser_state_t      dbg_state_o
);

  localparam logic [MOD_W-1:0] FULL_CNT = MOD_W'(DATA_W);

  deser_state_t      r_state;
  deser_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_sreg;
  logic [MOD_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_sreg_shift;
  logic [DATA_W-1:0] w_short_word;
  logic [MOD_W-1:0]  w_cnt_inc;
  logic              w_close;
  logic [DATA_W-1:0] w_word;
  logic [MOD_W-1:0]  w_mod;

  assign w_sreg_shift = {r_sreg[DATA_W-2:0], ser_data_i};
  assign w_cnt_inc    = r_cnt + 1'b1;
  // Only the low r_cnt bits belong to this word; older bits fall off the top.
  assign w_short_word = r_sreg << (FULL_CNT - r_cnt);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ser_data_val_i) w_state_nxt = COLLECT;
      COLLECT: if (!ser_data_val_i || (w_cnt_inc == FULL_CNT)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_close = 1'b0;
    w_word  = '0;
    w_mod   = '0;
    if (r_state == COLLECT) begin
      if (ser_data_val_i && (w_cnt_inc == FULL_CNT)) begin
        w_close = 1'b1;
        w_word  = w_sreg_shift;
        w_mod   = FULL_CNT;
      end else if (!ser_data_val_i) begin
        w_close = 1'b1;
        w_word  = w_short_word;
        w_mod   = r_cnt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else begin
      if (ser_data_val_i) r_sreg <= w_sreg_shift;
      if (w_close) begin
        r_cnt <= '0;
      end else if (ser_data_val_i) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  deser_out_slot #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W)
  ) u_slot (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .load_i   (w_close),
    .word_i   (w_word),
    .mod_i    (w_mod),
    .ready_i  (deser_ready_i),
    .data_o   (deser_data_o),
    .mod_o    (deser_mod_o),
    .valid_o  (deser_data_val_o),
    .drop_o   (overflow_o)
  );

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_deserializer;
  import deser_pkg::*;

  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W) + 1;
  localparam int EXP_W  = DATA_W + MOD_W;

  logic              clk;
  logic              arst_n;
  logic              ser_data;
  logic              ser_val;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [MOD_W-1:0]  mod;
  logic              val;
  logic              ovf;
  deser_state_t      dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int check_cnt = 0;
  int pass_cnt  = 0;
  int ovf_cnt   = 0;

  deserializer #(.DATA_W(DATA_W)) dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .ser_data_i       (ser_data),
    .ser_data_val_i   (ser_val),
    .deser_ready_i    (ready),
    .deser_data_o     (data),
    .deser_mod_o      (mod),
    .deser_data_val_o (val),
    .overflow_o       (ovf),
    .dbg_state_o      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout sim time exceeded budget");
    $fatal(1, "timeout");
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
  endfunction

  // scoreboard monitor: a transfer happens on the next posedge when val & ready
  always @(negedge clk) begin
    if (arst_n) begin
      if (ovf) ovf_cnt++;
      if (val && ready) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_word got=0x%0h/%0d expected none", data, mod);
        end else begin
          check("word", 32'({data, mod}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] w, input int m);
    exp_q.push_back({w, MOD_W'(m)});
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      ser_val  = 1'b1;
      ser_data = w[DATA_W-1-i];
      step();
    end
  endtask

  task automatic idle(input int n);
    ser_val  = 1'b0;
    ser_data = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    arst_n   = 1'b0;
    ser_data = 1'b0;
    ser_val  = 1'b0;
    ready    = 1'b0;
    #12;
    check("reset_data", 32'(data), 32'h0);
    check("reset_mod", 32'(mod), 32'h0);
    check("reset_val", 32'(val), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 arst_n = 1'b1;
    step();

    // 1: full word
    ready = 1'b1;
    expect_word(16'hA5C3, 16);
    send_bits(16'hA5C3, 16);
    check("t1_val_after_last_bit", 32'(val), 32'h1);
    idle(1);
    check("t1_val_dropped", 32'(val), 32'h0);

    // 2: short burst 1,0,1
    expect_word(16'hA000, 3);
    send_bits(16'hA000, 3);
    check("t2_val_before_gap", 32'(val), 32'h0);
    idle(1);
    check("t2_val_after_gap", 32'(val), 32'h1);
    idle(2);

    // 3: back-to-back words
    expect_word(16'h1234, 16);
    expect_word(16'hFFFF, 16);
    send_bits(16'h1234, 16);
    send_bits(16'hFFFF, 16);
    idle(3);
    check("t3_no_overflow", 32'(ovf_cnt), 32'h0);

    // 4: backpressure, second word dropped
    ready = 1'b0;
    expect_word(16'h1234, 16);
    send_bits(16'h1234, 16);
    send_bits(16'h5678, 16);
    check("t4_overflow_pulse", 32'(ovf), 32'h1);
    check("t4_held_data", 32'(data), 32'h1234);
    idle(1);
    check("t4_overflow_cleared", 32'(ovf), 32'h0);
    check("t4_held_mod", 32'(mod), 32'd16);
    check("t4_held_val", 32'(val), 32'h1);
    ready = 1'b1;
    step();
    check("t4_val_after_xfer", 32'(val), 32'h0);
    check("t4_overflow_total", 32'(ovf_cnt), 32'h1);

    // 5: transfer and load on the same edge
    ready = 1'b0;
    expect_word(16'h1111, 16);
    expect_word(16'h8000, 1);
    send_bits(16'h1111, 16);
    idle(1);
    send_bits(16'h8000, 1);
    ready = 1'b1;
    idle(1);
    check("t5_val_stays", 32'(val), 32'h1);
    check("t5_new_data", 32'(data), 32'h8000);
    check("t5_new_mod", 32'(mod), 32'h1);
    check("t5_no_overflow", 32'(ovf), 32'h0);
    step();
    check("t5_val_after_drain", 32'(val), 32'h0);

    // 6: async reset mid-burst
    send_bits(16'hFFFF, 7);
    #2 arst_n = 1'b0;
    #1;
    check("t6_reset_data", 32'(data), 32'h0);
    check("t6_reset_mod", 32'(mod), 32'h0);
    check("t6_reset_state", 32'(dbg_state), 32'(IDLE));
    ser_val = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
    step();
    expect_word(16'hBEEF, 16);
    send_bits(16'hBEEF, 16);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("overflow_total", 32'(ovf_cnt), 32'h1);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
